// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel
// double-buffered duty commands that take effect only at the frame boundary.
module servo_pwm_multi #(
    parameter int CHANNELS   = 4,
    parameter int DUTY_W     = 9,
    parameter int PERIOD_CYC = 100000,
    parameter int MIN_CYC    = 5000,
    parameter int MAX_CYC    = 10000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*DUTY_W-1:0] duty,
    input  logic [CHANNELS-1:0]        duty_wr,
    input  logic                       enable,
    output logic [CHANNELS-1:0]        pwm,
    output logic                       period_tick,
    output logic [CHANNELS-1:0]        update_pending
);

    localparam int CNT_W  = $clog2(PERIOD_CYC);
    localparam int SPAN   = MAX_CYC - MIN_CYC;
    localparam int SPAN_W = $clog2(SPAN + 1);
    localparam int PROD_W = DUTY_W + SPAN_W;

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0]  MIN_W    = CNT_W'(MIN_CYC);
    localparam logic [PROD_W-1:0] SPAN_P   = PROD_W'(SPAN);

    logic [CNT_W-1:0]  count;
    logic              boundary;
    logic              active_en;
    logic [DUTY_W-1:0] staged       [CHANNELS];
    logic [CNT_W-1:0]  active_width [CHANNELS];
    logic [CNT_W-1:0]  staged_width [CHANNELS];
    logic [PROD_W-1:0] product      [CHANNELS];

    assign boundary = (count == LAST_CNT);

    // The product is wide enough for the largest duty times the full span, so
    // the shifted result never exceeds SPAN and always fits the counter width.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            product[i]      = PROD_W'(staged[i]) * SPAN_P;
            staged_width[i] = MIN_W + CNT_W'(product[i] >> DUTY_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            period_tick <= 1'b0;
            active_en   <= 1'b0;
        end else begin
            count       <= boundary ? '0 : count + 1'b1;
            period_tick <= (count == '0);
            if (boundary) begin
                active_en <= enable;
            end
        end
    end

    // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are
    // reset explicitly; a reset must discard every staged command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm            <= '0;
            update_pending <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                staged[i]       <= '0;
                active_width[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm[i] <= active_en && (count < active_width[i]);
                // A write on the boundary edge itself loads staging while the
                // active width takes the value staged before that write.
                if (boundary) begin
                    active_width[i] <= staged_width[i];
                end
                if (duty_wr[i]) begin
                    staged[i]         <= duty[i*DUTY_W +: DUTY_W];
                    update_pending[i] <= 1'b1;
                end else if (boundary) begin
                    update_pending[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with a shortened frame (P=2000, widths
// 500..1000) so every scenario fits in a few tens of thousands of cycles.
module tb_servo_pwm_multi;

    localparam int CH   = 4;
    localparam int DW   = 9;
    localparam int P    = 2000;
    localparam int MINC = 500;
    localparam int MAXC = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*DW-1:0] duty;
    logic [CH-1:0]    duty_wr;
    logic             enable;
    logic [CH-1:0]    pwm;
    logic             period_tick;
    logic [CH-1:0]    update_pending;

    servo_pwm_multi #(
        .CHANNELS  (CH),
        .DUTY_W    (DW),
        .PERIOD_CYC(P),
        .MIN_CYC   (MINC),
        .MAX_CYC   (MAXC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .duty          (duty),
        .duty_wr       (duty_wr),
        .enable        (enable),
        .pwm           (pwm),
        .period_tick   (period_tick),
        .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 0;
    int waited   = 0;

    // Frame monitor: per-channel high-cycle totals, closed out at each tick.
    int          run    [CH] = '{default: 0};
    int          last_w [CH] = '{default: 0};
    logic [CH-1:0] first_pwm = '0;
    int          gap      = 0;
    int          last_gap = 0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) run[i] = 0;
            gap = 0;
        end else if (period_tick) begin
            for (int i = 0; i < CH; i++) begin
                last_w[i] = run[i];
                run[i]    = int'(pwm[i]);
            end
            first_pwm = pwm;
            last_gap  = gap;
            gap       = 1;
        end else begin
            for (int i = 0; i < CH; i++) run[i] = run[i] + int'(pwm[i]);
            gap = gap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // cur = counter value sampled by the next rising edge
    task automatic step();
        @(negedge clk);
        #1;
        cur++;
    endtask

    task automatic goto_count(input int n);
        while (cur < n) step();
    endtask

    task automatic wait_tick(output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 3*P) begin
            step();
            n++;
            if (period_tick) seen = 1'b1;
        end
        check("tick_seen", 32'(seen), 32'd1);
        cur = 1;
    endtask

    task automatic write_duty(input logic [CH-1:0] mask, input int d0, input int d1,
                              input int d2, input int d3);
        duty    = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
        duty_wr = mask;
        step();
        duty_wr = '0;
    endtask

    initial begin
        rst     = 1'b0;
        enable  = 1'b0;
        duty    = '0;
        duty_wr = '0;

        // Reset and idle frames
        repeat (10) @(negedge clk);
        #1;
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_tick", 32'(period_tick), 32'd0);
        check("rst_pending", 32'(update_pending), 32'd0);
        rst = 1'b1;
        wait_tick(waited);
        check("first_tick_latency", waited, 32'd1);
        for (int f = 0; f < 3; f++) begin
            wait_tick(waited);
            check("idle_gap", last_gap, P);
            check("idle_w0", last_w[0], 32'd0);
            check("idle_w3", last_w[3], 32'd0);
        end

        // Mapping: 0/256/511/128 -> 500/750/999/625
        enable = 1'b1;
        write_duty(4'hF, 0, 256, 511, 128);
        check("map_pending_set", 32'(update_pending), 32'hF);
        wait_tick(waited);
        check("map_pending_clr", 32'(update_pending), 32'd0);
        check("map_rise_aligned", 32'(first_pwm), 32'hF);
        wait_tick(waited);
        check("map_w0", last_w[0], 32'd500);
        check("map_w1", last_w[1], 32'd750);
        check("map_w2", last_w[2], 32'd999);
        check("map_w3", last_w[3], 32'd625);

        // Mid-frame update on channel 0
        goto_count(600);
        write_duty(4'b0001, 511, 0, 0, 0);
        check("mid_pending_set", 32'(update_pending), 32'b0001);
        goto_count(P-1);
        check("mid_pending_hold", 32'(update_pending[0]), 32'd1);
        wait_tick(waited);
        check("mid_pending_clr", 32'(update_pending[0]), 32'd0);
        check("mid_cur_w0", last_w[0], 32'd500);
        wait_tick(waited);
        check("mid_next_w0", last_w[0], 32'd999);
        check("mid_other_w1", last_w[1], 32'd750);

        // Write colliding with the boundary edge
        write_duty(4'b0001, 0, 0, 0, 0);
        goto_count(P-1);
        write_duty(4'b0001, 511, 0, 0, 0);
        wait_tick(waited);
        check("col_pending_kept", 32'(update_pending[0]), 32'd1);
        check("col_prev_w0", last_w[0], 32'd999);
        wait_tick(waited);
        check("col_first_w0", last_w[0], 32'd500);
        check("col_pending_clr", 32'(update_pending[0]), 32'd0);
        wait_tick(waited);
        check("col_second_w0", last_w[0], 32'd999);

        // Enable sampled only at the boundary
        goto_count(400);
        enable = 1'b0;
        step();
        wait_tick(waited);
        check("en_drop_full_w1", last_w[1], 32'd750);
        goto_count(1000);
        enable = 1'b1;
        step();
        wait_tick(waited);
        check("en_off_w1", last_w[1], 32'd0);
        check("en_off_w0", last_w[0], 32'd0);
        check("en_resume_rise", 32'(first_pwm), 32'hF);
        wait_tick(waited);
        check("en_resume_w1", last_w[1], 32'd750);
        check("en_resume_w3", last_w[3], 32'd625);

        // Asynchronous reset in the middle of a pulse
        goto_count(800);
        check("pre_rst_pwm", 32'(pwm), 32'b0101);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm), 32'd0);
        check("async_rst_pending", 32'(update_pending), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        wait_tick(waited);
        check("post_rst_tick_latency", waited, 32'd1);
        wait_tick(waited);
        check("post_rst_frameA_w0", last_w[0], 32'd0);
        check("post_rst_frameA_w2", last_w[2], 32'd0);
        wait_tick(waited);
        for (int i = 0; i < CH; i++) begin
            check($sformatf("post_rst_frameB_w%0d", i), last_w[i], 32'd500);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
